// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving a shared-memory, single-ALU MIPS datapath.
// Controls are combinational in state and IR fields; memory waits stall in place and abort after MEM_TIMEOUT cycles.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int WAIT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_sel,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic       ALUSrc,
    output logic [1:0] DatatoReg,
    output logic [1:0] PC_sel,
    output logic       ExtOp,
    output logic [4:0] ALUCtrl,
    output logic       IsJump,
    output logic       illegal,
    output logic       bus_err,
    output logic       instr_done,
    output logic [2:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [4:0] ALUOp_NOP  = 5'd0;
    localparam logic [4:0] ALUOp_ADD  = 5'd1;
    localparam logic [4:0] ALUOp_SUB  = 5'd2;
    localparam logic [4:0] ALUOp_OR   = 5'd3;
    localparam logic [4:0] ALUOp_SLT  = 5'd4;
    localparam logic [4:0] ALUOp_LUI  = 5'd5;
    localparam logic [4:0] ALUOp_EQL  = 5'd6;
    localparam logic [4:0] ALUOp_BNE  = 5'd7;
    localparam logic [4:0] ALUOp_ADDU = 5'd8;
    localparam logic [4:0] ALUOp_SUBU = 5'd9;

    localparam logic [1:0] REG_MUX_SEL_RT      = 2'd0;
    localparam logic [1:0] REG_MUX_SEL_RD      = 2'd1;
    localparam logic       ALU_SRC_MUX_SEL_REG = 1'b0;
    localparam logic       ALU_SRC_MUX_SEL_EXT = 1'b1;
    localparam logic [1:0] DR_MUX_SEL_ALU      = 2'd0;
    localparam logic [1:0] DR_MUX_SEL_MEM      = 2'd1;
    localparam logic [1:0] PC_MUX_SEL_NEWPC    = 2'd0;
    localparam logic [1:0] PC_MUX_SEL_BRANCH   = 2'd1;
    localparam logic       EXT_ZERO            = 1'b0;
    localparam logic       EXT_SIGNED          = 1'b1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic       is_rtype, func_ok, supported, timeout;
    logic [4:0] dec_alu;
    logic       dec_src, dec_ext;

    always_comb begin
        is_rtype = (opcode == OP_RTYPE);
        func_ok  = (func == FN_ADD) || (func == FN_ADDU) || (func == FN_SUB) ||
                   (func == FN_SUBU) || (func == FN_SLT);
        supported = (is_rtype && func_ok) ||
                    (opcode == OP_ORI) || (opcode == OP_LUI) || (opcode == OP_SLTI) ||
                    (opcode == OP_LW)  || (opcode == OP_SW)  || (opcode == OP_BEQ)  ||
                    (opcode == OP_BNE) || (opcode == OP_J);
    end

    // ALU setup per instruction; only driven onto the outputs in EXEC
    always_comb begin
        dec_alu = ALUOp_NOP;
        dec_src = ALU_SRC_MUX_SEL_REG;
        dec_ext = EXT_ZERO;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  dec_alu = ALUOp_ADD;
                    FN_ADDU: dec_alu = ALUOp_ADDU;
                    FN_SUB:  dec_alu = ALUOp_SUB;
                    FN_SUBU: dec_alu = ALUOp_SUBU;
                    FN_SLT:  dec_alu = ALUOp_SLT;
                    default: dec_alu = ALUOp_NOP;
                endcase
            end
            OP_ORI: begin
                dec_alu = ALUOp_OR;
                dec_src = ALU_SRC_MUX_SEL_EXT;
            end
            OP_LUI: begin
                dec_alu = ALUOp_LUI;
                dec_src = ALU_SRC_MUX_SEL_EXT;
            end
            OP_SLTI: begin
                dec_alu = ALUOp_SLT;
                dec_src = ALU_SRC_MUX_SEL_EXT;
                dec_ext = EXT_SIGNED;
            end
            OP_LW, OP_SW: begin
                dec_alu = ALUOp_ADD;
                dec_src = ALU_SRC_MUX_SEL_EXT;
                dec_ext = EXT_SIGNED;
            end
            OP_BEQ:  dec_alu = ALUOp_EQL;
            OP_BNE:  dec_alu = ALUOp_BNE;
            default: dec_alu = ALUOp_NOP;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        mem_req    = 1'b0;
        mem_sel    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = REG_MUX_SEL_RT;
        ALUSrc     = ALU_SRC_MUX_SEL_REG;
        DatatoReg  = DR_MUX_SEL_ALU;
        PC_sel     = PC_MUX_SEL_NEWPC;
        ExtOp      = EXT_ZERO;
        ALUCtrl    = ALUOp_NOP;
        IsJump     = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        instr_done = 1'b0;
        // The abort cycle itself drops the request so the memory sees no further strobe
        timeout    = (wait_q == WAIT_W'(MEM_TIMEOUT)) && !mem_ready;

        case (state_q)
            S_FETCH: begin
                if (timeout) begin
                    bus_err = 1'b1;
                end else begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        PC_sel  = PC_MUX_SEL_NEWPC;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (!supported) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else if (opcode == OP_J) begin
                    IsJump     = 1'b1;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUCtrl = dec_alu;
                ALUSrc  = dec_src;
                ExtOp   = dec_ext;
                if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    PC_sel     = PC_MUX_SEL_BRANCH;
                    PCWrite    = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (timeout) begin
                    bus_err = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    mem_req  = 1'b1;
                    mem_sel  = 1'b1;
                    MemRead  = (opcode == OP_LW);
                    MemWrite = (opcode == OP_SW);
                    if (mem_ready) begin
                        if (opcode == OP_LW) begin
                            state_d = S_WB;
                        end else begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                RegDst     = is_rtype ? REG_MUX_SEL_RD : REG_MUX_SEL_RT;
                DatatoReg  = (opcode == OP_LW) ? DR_MUX_SEL_MEM : DR_MUX_SEL_ALU;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // A fetch abort stays in FETCH, so it must clear the counter explicitly
        if (state_d != state_q || timeout) begin
            wait_d = '0;
        end else if (mem_req && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign state = state_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS core. It replaces single-cycle decode with a sequenced FETCH/DECODE/EXEC/MEM/WB flow, so one shared instruction/data memory and one ALU serve every instruction. It sits beside the datapath: it takes IR fields, the ALU zero flag and the memory ready handshake, and drives every datapath mux select and write enable.

## Interface
- MEM_TIMEOUT, 255: maximum wait cycles per memory access before abort; range 1..2^WAIT_W−1.
- WAIT_W, 8: width of the wait counter.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- func  in  6  IR[5:0].
- alu_zero  in  1  ALU zero flag; sampled in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_sel  out  1  address source: 0 = PC (instruction), 1 = ALUOut (data).
- MemRead / MemWrite  out  1 each  memory read / write strobe.
- IRWrite, PCWrite, RegWrite  out  1 each  register write enables.
- RegDst  out  2  REG_MUX_SEL_RT / REG_MUX_SEL_RD.
- ALUSrc  out  1  ALU_SRC_MUX_SEL_REG / ALU_SRC_MUX_SEL_EXT.
- DatatoReg  out  2  DR_MUX_SEL_ALU / DR_MUX_SEL_MEM.
- PC_sel  out  2  PC_MUX_SEL_NEWPC / PC_MUX_SEL_BRANCH.
- ExtOp  out  1  EXT_SIGNED / EXT_ZERO.
- ALUCtrl  out  5  ALUOp_* code from ctrl_encode_def.v.
- IsJump  out  1  PC takes the jump target.
- illegal, bus_err, instr_done  out  1 each  single-cycle status pulses.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.

## Operation
- All outputs are combinational in state and IR fields; PCWrite in EXEC also depends on alu_zero. Every control not listed for a state is 0.
- Supported instructions (hex): R-type 00 with func add 20, addu 21, sub 22, subu 23, slt 2A; ori 0D, lui 0F, slti 0A, lw 23, sw 2B, beq 04, bne 05, j 02.
- FETCH: mem_req=1, mem_sel=0, MemRead=1.
  - Hold until mem_ready.
  - On the ready cycle: IRWrite=1, PCWrite=1, PC_sel=NEWPC (PC+4); next state DECODE.
- DECODE:
  - Unsupported opcode or func: illegal=1, then FETCH (treated as NOP).
  - j: IsJump=1, PCWrite=1, instr_done=1, then FETCH.
  - Otherwise go to EXEC.
- EXEC: ALUCtrl, ALUSrc and ExtOp follow the instruction.
  - R-type uses REG; ori uses EXT/ZERO/OR; lui uses EXT/ZERO/LUI; slti uses EXT/SIGNED/SLT; lw and sw use EXT/SIGNED/ADD.
  - beq uses ALUOp_EQL; bne uses ALUOp_BNE.
  - beq/bne: PC_sel=BRANCH. PCWrite = alu_zero for beq and !alu_zero for bne. instr_done=1, then FETCH.
  - lw/sw go to MEM; all others go to WB.
- MEM: mem_req=1, mem_sel=1, MemRead (lw) or MemWrite (sw), held stable until mem_ready.
  - sw: on ready, instr_done=1, then FETCH.
  - lw: on ready, go to WB.
- WB: RegWrite=1, instr_done=1, then FETCH.
  - RegDst=RD for R-type, RT otherwise.
  - DatatoReg=MEM for lw, ALU otherwise.
- Wait counter: cleared on entry to FETCH or MEM and increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: bus_err=1 for one cycle, mem_req drops, state goes to FETCH.
  - No PC, IR or register write occurs for the aborted instruction. A fetch timeout retries the same PC.

## Timing
- Reset: state=FETCH, wait counter=0; all outputs except the FETCH controls are 0. In FETCH, mem_req, MemRead and mem_sel=0 follow from the state.
- Reset mid-access drops the access; mem_req reasserts as a fresh fetch on the first cycle after rst falls.
- With zero-wait memory (mem_ready high in the request cycle): j 2 cycles, branch 3, R-type/immediate 4, sw 4, lw 5.
- Each wait cycle adds one cycle; mem_req, mem_sel and the strobes never change while waiting.
- mem_ready outside FETCH/MEM is ignored.
- instr_done, illegal and bus_err are mutually exclusive, one cycle each; at most one per instruction.

## Test plan
- Reset, zero-wait memory, addu (opcode 00, func 21) -> state sequence 0,1,2,4,0; RegWrite=1 only in WB with RegDst=RD; instr_done pulses once; 4 cycles total.
- lw (23) with mem_ready delayed 3 cycles in both FETCH and MEM -> 11 cycles; MemRead and mem_sel held stable while waiting; WB has DatatoReg=MEM, RegDst=RT.
- beq (04) with alu_zero=1, then alu_zero=0 -> PCWrite=1 with PC_sel=BRANCH in EXEC for the first, PCWrite=0 for the second; bne (05) is the inverse; 3 cycles each.
- j (02) -> IsJump=1, PCWrite=1 in DECODE, back to FETCH after 2 cycles; opcode 3F -> illegal pulse, no writes.
- Run with MEM_TIMEOUT=4 and mem_ready held 0 during a sw MEM phase -> bus_err after 4 wait cycles; MemWrite drops; FETCH follows; no RegWrite.
- rst asserted in MEM for sw -> state=0 and MemWrite=0 on the next cycle; a clean fetch follows after release.
